// File: rtl/cmb_ctrl_pkg.sv
// Shared constants and the round-robin pick helper for the button/sensor command arbiter.
// Pure combinational helpers only; no state lives here.
package cmb_ctrl_pkg;

  localparam int MAX_LANES     = 16;
  localparam int PTRW          = 4;
  localparam int DROPW_DEFAULT = 8;

  // Rotate-and-priority-encode: first set bit of pend at or after ptr, wrapping at n.
  // Returns {found, winner}; winner is 0 when nothing is pending.
  function automatic logic [PTRW:0] rr_pick(
    input logic [MAX_LANES-1:0] pend,
    input logic [PTRW-1:0]      ptr,
    input int                   n
  );
    logic            found;
    logic [PTRW-1:0] w;
    logic [PTRW:0]   idx;
    found = 1'b0;
    w     = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      idx = {1'b0, ptr} + (PTRW+1)'(i);
      if (idx >= (PTRW+1)'(n)) idx = idx - (PTRW+1)'(n);
      if ((i < n) && !found && pend[idx[PTRW-1:0]]) begin
        found = 1'b1;
        w     = idx[PTRW-1:0];
      end
    end
    return {found, w};
  endfunction

endpackage

// File: rtl/btn_cmd_arbiter_edge_rise.sv
// Vector-wide rising-edge detector; rise is combinational from sig and one registered copy.
// History resets to all-ones so lines held high through reset never produce an edge.
module edge_rise #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sig,
  output logic [N-1:0] rise
);

  logic [N-1:0] sig_d;

  always_ff @(posedge clk) begin
    if (!rst_n) sig_d <= '1;
    else        sig_d <= sig;
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Edge-triggered lane events -> one-deep pending latches -> round-robin -> registered cmd port.
// Latency: 2 clk best case from input edge to cmd_valid; cmd_id held stable while stalled.
// Backpressure: cmd_ready low holds the output; repeat edges on a pending lane are dropped and counted.
module btn_cmd_arbiter
  import cmb_ctrl_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int DROPW = DROPW_DEFAULT,
  localparam int IDW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     sig,
  output logic             cmd_valid,
  output logic [IDW-1:0]   cmd_id,
  input  logic             cmd_ready,
  output logic [N-1:0]     pending,
  output logic [DROPW-1:0] drop_cnt
);

  localparam int SUMW = DROPW + $clog2(N) + 1;

  if (N < 2 || N > MAX_LANES) begin : g_bad_n
    $error("btn_cmd_arbiter: N out of range");
  end

  logic [N-1:0]         rise;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       ptr_nxt;
  logic [MAX_LANES-1:0] pend_ext;
  logic [PTRW:0]        pick;
  logic                 found;
  logic [PTRW-1:0]      w;
  logic                 load;
  logic                 grant;
  logic [N-1:0]         grant_clr;
  logic [N-1:0]         drop;
  logic [N-1:0]         pending_nxt;
  logic [SUMW-1:0]      drop_sum;
  logic [DROPW-1:0]     drop_nxt;

  edge_rise #(.N(N)) u_edge_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (sig),
    .rise  (rise)
  );

  // Only registered pending is eligible; same-cycle rises wait one cycle.
  always_comb begin
    pend_ext          = '0;
    pend_ext[N-1:0]   = pending;
    pick              = rr_pick(pend_ext, PTRW'(rr_ptr), N);
    found             = pick[PTRW];
    w                 = pick[PTRW-1:0];
    load              = ~cmd_valid | cmd_ready;
    grant             = load & found;
    ptr_nxt           = (w == PTRW'(N-1)) ? '0 : IDW'(w + 1'b1);
  end

  // A rise on a lane being granted re-arms it, so the new event survives.
  always_comb begin
    grant_clr   = '0;
    drop        = '0;
    pending_nxt = pending;
    drop_sum    = SUMW'(drop_cnt);
    for (int i = 0; i < N; i++) begin
      grant_clr[i] = grant && (w == PTRW'(i));
      drop[i]      = rise[i] & pending[i] & ~grant_clr[i];
      if (rise[i])           pending_nxt[i] = 1'b1;
      else if (grant_clr[i]) pending_nxt[i] = 1'b0;
      drop_sum = drop_sum + SUMW'(drop[i]);
    end
    drop_nxt = (drop_sum > SUMW'({DROPW{1'b1}})) ? {DROPW{1'b1}} : drop_sum[DROPW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      rr_ptr    <= '0;
      drop_cnt  <= '0;
    end else begin
      pending  <= pending_nxt;
      drop_cnt <= drop_nxt;
      if (load) begin
        cmd_valid <= found;
        if (found) begin
          cmd_id <= w[IDW-1:0];
          rr_ptr <= ptr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed bench for btn_cmd_arbiter (N=4): reset, latency, round-robin order, backpressure, drops, saturation.
module tb_btn_cmd_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_ready;
  logic [3:0] pending;
  logic [7:0] drop_cnt;

  int checks;
  int errors;

  btn_cmd_arbiter #(.N(4), .DROPW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig       (sig),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .cmd_ready (cmd_ready),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sig   = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bit seen;
    rst_n     = 1'b0;
    sig       = 4'b0101;
    cmd_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_id !== 2'd0 || pending !== 4'b0000 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state valid=%b id=%0d pend=%b drop=%0d want 0 0 0000 0",
               cmd_valid, cmd_id, pending, drop_cnt);
    end
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_held_high cmd_valid seen=1 want 0");
    end
    checks++;
    if (pending !== 4'b0000 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_held_status pend=%b drop=%0d want 0000 0", pending, drop_cnt);
    end
    sig = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    cmd_ready = 1'b1;
    sig = 4'b0100;
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || pending !== 4'b0100) begin
      errors++;
      $display("FAIL single_edge_k valid=%b pend=%b want 0 0100", cmd_valid, pending);
    end
    sig = 4'b0000;
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_edge_k1 valid=%b id=%0d pend=%b want 1 2 0000", cmd_valid, cmd_id, pending);
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle valid=%b want 0", cmd_valid);
    end
    // rr_ptr should now be 3: lanes 0 and 3 together must grant 3 first
    sig = 4'b1001;
    tick();
    sig = 4'b0000;
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd3) begin
      errors++;
      $display("FAIL single_ptr_after valid=%b id=%0d want 1 3", cmd_valid, cmd_id);
    end
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a [4];
    logic [1:0] exp_b [2];
    logic [1:0] exp_c [2];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_b = '{2'd0, 2'd3};
    exp_c = '{2'd3, 2'd0};
    do_reset();
    cmd_ready = 1'b1;
    sig = 4'b1111;
    tick();
    sig = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_id !== exp_a[i]) begin
        errors++;
        $display("FAIL rr_all4[%0d] valid=%b id=%0d want 1 %0d", i, cmd_valid, cmd_id, exp_a[i]);
      end
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL rr_all4_drain valid=%b pend=%b want 0 0000", cmd_valid, pending);
    end
    sig = 4'b1001;
    tick();
    sig = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_id !== exp_b[i]) begin
        errors++;
        $display("FAIL rr_03_ptr0[%0d] valid=%b id=%0d want 1 %0d", i, cmd_valid, cmd_id, exp_b[i]);
      end
    end
    tick();
    // lone lane 0 moves rr_ptr to 1
    sig = 4'b0001;
    tick();
    sig = 4'b0000;
    tick();
    tick();
    sig = 4'b1001;
    tick();
    sig = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_id !== exp_c[i]) begin
        errors++;
        $display("FAIL rr_03_ptr1[%0d] valid=%b id=%0d want 1 %0d", i, cmd_valid, cmd_id, exp_c[i]);
      end
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_03_ptr1_drain valid=%b want 0", cmd_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cmd_ready = 1'b0;
    sig = 4'b0010;
    tick();
    sig = 4'b0000;
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd1 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL bp_load valid=%b id=%0d pend=%b want 1 1 0000", cmd_valid, cmd_id, pending);
    end
    sig = 4'b0010;
    tick();
    sig = 4'b0000;
    tick();
    sig = 4'b0010;
    tick();
    sig = 4'b0000;
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd1 || pending !== 4'b0010 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_hold valid=%b id=%0d pend=%b drop=%0d want 1 1 0010 1",
               cmd_valid, cmd_id, pending, drop_cnt);
    end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd1 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL bp_second valid=%b id=%0d pend=%b want 1 1 0000", cmd_valid, cmd_id, pending);
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain valid=%b want 0", cmd_valid);
    end
  endtask

  task automatic test_multi_drop();
    do_reset();
    cmd_ready = 1'b0;
    sig = 4'b1111;
    tick();
    sig = 4'b0000;
    tick();
    // lane 0 is in the output register; lanes 1..3 still pending
    sig = 4'b1111;
    tick();
    checks++;
    if (drop_cnt !== 8'd3 || pending !== 4'b1111 || cmd_id !== 2'd0) begin
      errors++;
      $display("FAIL multi_drop drop=%0d pend=%b id=%0d want 3 1111 0", drop_cnt, pending, cmd_id);
    end
    sig = 4'b0000;
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    cmd_ready = 1'b0;
    for (int p = 0; p < 202; p++) begin
      sig = 4'b0001;
      tick();
      sig = 4'b0000;
      tick();
    end
    checks++;
    if (drop_cnt !== 8'd200) begin
      errors++;
      $display("FAIL sat_mid drop=%0d want 200", drop_cnt);
    end
    for (int p = 0; p < 100; p++) begin
      sig = 4'b0001;
      tick();
      sig = 4'b0000;
      tick();
    end
    checks++;
    if (drop_cnt !== 8'd255 || cmd_valid !== 1'b1 || cmd_id !== 2'd0) begin
      errors++;
      $display("FAIL sat_top drop=%0d valid=%b id=%0d want 255 1 0", drop_cnt, cmd_valid, cmd_id);
    end
    rst_n = 1'b0;
    sig   = 4'b0001;
    tick();
    rst_n = 1'b1;
    checks++;
    if (cmd_valid !== 1'b0 || drop_cnt !== 8'd0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL sat_reset valid=%b drop=%0d pend=%b want 0 0 0000", cmd_valid, drop_cnt, pending);
    end
    cmd_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL sat_post_reset valid=%b pend=%b want 0 0000", cmd_valid, pending);
    end
    sig = 4'b0000;
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    sig       = 4'b0000;
    cmd_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_multi_drop();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
